// File: rtl/pwm_carrier_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_carrier_bank_pkg
// Description : Shared types and constants for the PWM carrier bank:
//               count modes, event mask modes, on/off selectors and the
//               default channel count.
// Revision    : 1.0 - initial parametrised N-channel release
// ============================================================================
package pwm_carrier_bank_pkg;

  // Default number of carrier channels in a bank
  localparam int CARRCH_WIDTH = 8;

  // Per-channel counting behaviour
  typedef enum logic [1:0] {
    NO_COUNT     = 2'd0,
    COUNT_UP     = 2'd1,
    COUNT_DOWN   = 2'd2,
    COUNT_UPDOWN = 2'd3
  } pwm_count_mode;

  // Bit0 suppresses min events, bit1 suppresses max events
  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } pwm_mask_mode;

  typedef enum logic {
    CARR_OFF = 1'b0,
    CARR_ON  = 1'b1
  } pwm_carr_onoff;

  typedef enum logic {
    CLKDIV_OFF = 1'b0,
    CLKDIV_ON  = 1'b1
  } pwm_clkdiv_onoff;

endpackage
`default_nettype wire

// File: rtl/pwm_carr_ch.sv
`default_nettype none
// ============================================================================
// Module      : pwm_carr_ch
// Description : One carrier channel: up/down/up-down counter with direction,
//               shadow period, extrema event detection and an interrupt
//               event decimator.
// Revision    : 1.0 - initial parametrised N-channel release
// ============================================================================
module pwm_carr_ch
  import pwm_carrier_bank_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int EVT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             sync_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       mask_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] phase_i,
  input  logic [EVT_W-1:0] evt_cnt_i,
  output logic [CNT_W-1:0] carr_o,
  output logic             dir_o,
  output logic             evt_o,
  output logic             irq_o
);

  pwm_count_mode    mode_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pa_q, pa_d;
  logic             dir_q, dir_d;
  logic [EVT_W-1:0] dec_q, dec_d;
  logic             evt_q, evt_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_dir;
  logic             hit_min, hit_max, fire;

  assign mode_e = pwm_count_mode'(mode_i);

  // Next-state: disable > sync > tick; events only ever come from a tick
  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pa_d    = pa_q;
    dec_d   = dec_q;
    evt_d   = 1'b0;
    irq_d   = 1'b0;
    nxt_cnt = cnt_q;
    nxt_dir = dir_q;
    hit_min = 1'b0;
    hit_max = 1'b0;
    fire    = 1'b0;
    if (en_i != CARR_ON) begin
      cnt_d = '0;
      dir_d = 1'b0;
      pa_d  = period_i;
      dec_d = '0;
    end else if (sync_i) begin
      pa_d  = period_i;
      cnt_d = (phase_i > period_i) ? period_i : phase_i;
      dir_d = (mode_e == COUNT_DOWN);
    end else if (tick_i && (mode_e != NO_COUNT)) begin
      if (pa_q == '0) begin
        // Degenerate period: pinned at zero, a min event every tick
        nxt_cnt = '0;
        nxt_dir = 1'b0;
      end else begin
        case (mode_e)
          COUNT_UP: begin
            nxt_cnt = (cnt_q >= pa_q) ? '0 : cnt_q + 1'b1;
            nxt_dir = 1'b0;
          end
          COUNT_DOWN: begin
            nxt_cnt = ((cnt_q == '0) || (cnt_q > pa_q)) ? pa_q : cnt_q - 1'b1;
            nxt_dir = 1'b1;
          end
          COUNT_UPDOWN: begin
            // A counter stranded above a shrunk period turns as if at the peak
            if ((cnt_q > pa_q) || (!dir_q && (cnt_q == pa_q))) begin
              nxt_cnt = pa_q - 1'b1;
              nxt_dir = 1'b1;
            end else if (!dir_q) begin
              nxt_cnt = cnt_q + 1'b1;
              nxt_dir = 1'b0;
            end else if (cnt_q == '0) begin
              nxt_cnt = CNT_W'(1);
              nxt_dir = 1'b0;
            end else begin
              nxt_cnt = cnt_q - 1'b1;
              nxt_dir = 1'b1;
            end
          end
          default: begin
            nxt_cnt = cnt_q;
            nxt_dir = dir_q;
          end
        endcase
      end
      hit_min = (nxt_cnt == '0);
      hit_max = (nxt_cnt == pa_q) && (pa_q != '0);
      fire    = (hit_min && !mask_i[0]) || (hit_max && !mask_i[1]);
      cnt_d   = nxt_cnt;
      dir_d   = nxt_dir;
      evt_d   = fire;
      if (fire) begin
        pa_d = period_i;
        if (dec_q == evt_cnt_i) begin
          dec_d = '0;
          irq_d = 1'b1;
        end else begin
          dec_d = dec_q + 1'b1;
        end
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      pa_q  <= '0;
      dec_q <= '0;
      evt_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      pa_q  <= pa_d;
      dec_q <= dec_d;
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign carr_o = cnt_q;
  assign dir_o  = dir_q;
  assign evt_o  = evt_q;
  assign irq_o  = irq_q;

endmodule
`default_nettype wire

// File: rtl/pwm_carrier_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_carrier_bank
// Description : N-channel PWM carrier generator with a shared prescaler and
//               one pwm_carr_ch instance per channel.
//               Build option CARR_PHASE_EN: when defined, sync loads each
//               counter with min(phase, period); otherwise sync loads zero
//               and the phase port is ignored.
// Revision    : 1.0 - initial parametrised N-channel release
// ============================================================================
module pwm_carrier_bank
  import pwm_carrier_bank_pkg::*;
#(
  parameter int N_CH  = CARRCH_WIDTH,
  parameter int CNT_W = 16,
  parameter int DIV_W = 4,
  parameter int EVT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [2*N_CH-1:0]     mask,
  input  logic                  clkdiv_en,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [N_CH*CNT_W-1:0] period,
  input  logic [N_CH*CNT_W-1:0] phase,
  input  logic [N_CH*EVT_W-1:0] evt_cnt,
  input  logic                  sync,
  output logic [N_CH*CNT_W-1:0] carr,
  output logic [N_CH-1:0]       dir,
  output logic [N_CH-1:0]       evt,
  output logic [N_CH-1:0]       irq
);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick;
  logic [N_CH*CNT_W-1:0] phase_sel;

`ifdef CARR_PHASE_EN
  assign phase_sel = phase;
`else
  logic unused_phase;
  assign unused_phase = ^phase;
  assign phase_sel    = '0;
`endif

  // Shared prescaler: free-running tick when off, otherwise every clkdiv+1
  always_comb begin
    tick  = 1'b1;
    div_d = '0;
    if (clkdiv_en == CLKDIV_ON) begin
      tick  = (div_q == clkdiv);
      div_d = tick ? '0 : div_q + 1'b1;
    end
    if (sync) begin
      div_d = '0;
    end
  end

  // Prescaler divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_carr_ch #(
      .CNT_W (CNT_W),
      .EVT_W (EVT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .sync_i    (sync),
      .en_i      (en[g]),
      .mode_i    (mode[2*g +: 2]),
      .mask_i    (mask[2*g +: 2]),
      .period_i  (period[g*CNT_W +: CNT_W]),
      .phase_i   (phase_sel[g*CNT_W +: CNT_W]),
      .evt_cnt_i (evt_cnt[g*EVT_W +: EVT_W]),
      .carr_o    (carr[g*CNT_W +: CNT_W]),
      .dir_o     (dir[g]),
      .evt_o     (evt[g]),
      .irq_o     (irq[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_carrier_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_carrier_bank
// Description : Self-checking bench for pwm_carrier_bank: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_carrier_bank;
  import pwm_carrier_bank_pkg::*;

  localparam int N_CH  = 8;
  localparam int CNT_W = 16;
  localparam int DIV_W = 4;
  localparam int EVT_W = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_CH-1:0]       en = '0;
  logic [2*N_CH-1:0]     mode = '0;
  logic [2*N_CH-1:0]     mask = '0;
  logic                  clkdiv_en = 1'b0;
  logic [DIV_W-1:0]      clkdiv = '0;
  logic [N_CH*CNT_W-1:0] period = '0;
  logic [N_CH*CNT_W-1:0] phase = '0;
  logic [N_CH*EVT_W-1:0] evt_cnt = '0;
  logic                  sync = 1'b0;
  logic [N_CH*CNT_W-1:0] carr;
  logic [N_CH-1:0]       dir, evt, irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_carr[N_CH];
  int m_pa[N_CH];
  int m_dec[N_CH];
  bit m_dir[N_CH];
  bit m_evt[N_CH];
  bit m_irq[N_CH];
  int m_div;

  always #5 clk = ~clk;

  pwm_carrier_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DIV_W(DIV_W), .EVT_W(EVT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .mask(mask),
    .clkdiv_en(clkdiv_en), .clkdiv(clkdiv), .period(period), .phase(phase),
    .evt_cnt(evt_cnt), .sync(sync), .carr(carr), .dir(dir), .evt(evt), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int carr_of(input int ch);
    return int'(carr[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic set_ch(input int ch, input int md, input int mk, input int p,
                        input int ph, input int ec);
    mode[2*ch +: 2]           = 2'(md);
    mask[2*ch +: 2]           = 2'(mk);
    period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    phase[ch*CNT_W +: CNT_W]  = CNT_W'(ph);
    evt_cnt[ch*EVT_W +: EVT_W] = EVT_W'(ec);
  endtask

  task automatic model_reset();
    m_div = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_carr[ch] = 0; m_pa[ch] = 0; m_dec[ch] = 0;
      m_dir[ch] = 0; m_evt[ch] = 0; m_irq[ch] = 0;
    end
  endtask

  // One clock of the behavioural model, from the inputs present at the edge
  task automatic model_step();
    bit tick;
    tick = !clkdiv_en || (m_div == int'(clkdiv));
    if (sync || !clkdiv_en || tick) m_div = 0;
    else m_div = (m_div + 1) % (1 << DIV_W);
    for (int ch = 0; ch < N_CH; ch++) begin
      int p, ph, md, mk, ec, nc, pos, per;
      bit nd, fire;
      p  = int'(period[ch*CNT_W +: CNT_W]);
      ph = int'(phase[ch*CNT_W +: CNT_W]);
      md = int'(mode[2*ch +: 2]);
      mk = int'(mask[2*ch +: 2]);
      ec = int'(evt_cnt[ch*EVT_W +: EVT_W]);
      m_evt[ch] = 0;
      m_irq[ch] = 0;
      if (!en[ch]) begin
        m_carr[ch] = 0; m_dir[ch] = 0; m_pa[ch] = p; m_dec[ch] = 0;
      end else if (sync) begin
        m_pa[ch] = p;
`ifdef CARR_PHASE_EN
        m_carr[ch] = (ph < p) ? ph : p;
`else
        m_carr[ch] = 0;
`endif
        m_dir[ch] = (md == 2);
      end else if (tick && md != 0) begin
        if (m_pa[ch] == 0) begin
          nc = 0; nd = 0;
        end else if (md == 1) begin
          nc = (m_carr[ch] > m_pa[ch]) ? 0 : (m_carr[ch] + 1) % (m_pa[ch] + 1);
          nd = 0;
        end else if (md == 2) begin
          nc = (m_carr[ch] > m_pa[ch]) ? m_pa[ch] : (m_carr[ch] + m_pa[ch]) % (m_pa[ch] + 1);
          nd = 1;
        end else begin
          // Triangle position 0..2P-1; above-period carriers act as the peak
          per = 2 * m_pa[ch];
          if (m_carr[ch] > m_pa[ch]) pos = m_pa[ch];
          else pos = m_dir[ch] ? per - m_carr[ch] : m_carr[ch];
          pos = (pos + 1) % per;
          nc  = (pos <= m_pa[ch]) ? pos : per - pos;
          nd  = (pos > m_pa[ch]) || (pos == 0);
        end
        fire = ((nc == 0) && !mk[0]) || ((nc == m_pa[ch]) && (m_pa[ch] != 0) && !mk[1]);
        m_carr[ch] = nc;
        m_dir[ch]  = nd;
        m_evt[ch]  = fire;
        if (fire) begin
          m_pa[ch] = p;
          if (m_dec[ch] == ec) begin
            m_dec[ch] = 0; m_irq[ch] = 1;
          end else begin
            m_dec[ch] = (m_dec[ch] + 1) % (1 << EVT_W);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N_CH*CNT_W-1:0] ec;
    logic [N_CH-1:0] ed, ee, ei;
    for (int ch = 0; ch < N_CH; ch++) begin
      ec[ch*CNT_W +: CNT_W] = CNT_W'(m_carr[ch]);
      ed[ch] = m_dir[ch];
      ee[ch] = m_evt[ch];
      ei[ch] = m_irq[ch];
    end
    check_eq("model_carr", carr, ec);
    check_eq("model_dir", dir, ed);
    check_eq("model_evt", evt, ee);
    check_eq("model_irq", irq, ei);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    compare_all();
  endtask

  task automatic random_config();
    for (int ch = 0; ch < N_CH; ch++) begin
      set_ch(ch, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12),
             $urandom_range(0, 15), $urandom_range(0, 7));
      en[ch] = ($urandom_range(0, 7) != 0);
    end
    clkdiv_en = $urandom_range(0, 1);
    clkdiv    = DIV_W'($urandom_range(0, 3));
  endtask

  int ud_seq[8]  = '{1, 2, 3, 4, 3, 2, 1, 0};
  int ud_dir[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    int guard, mx, v, exp_sync;
    model_reset();
    // Reset state
    step_cycle();
    check_eq("reset_carr", carr, 0);
    check_eq("reset_flags", {dir, evt, irq}, 0);
    rst_n = 1'b1;

    // Directed channel set-up, Pa captured while disabled
    set_ch(0, 1, 0, 3, 0, 0);   // UP P=3 no mask
    set_ch(1, 3, 1, 4, 0, 0);   // UPDOWN P=4 min masked
    set_ch(2, 1, 0, 2, 0, 0);   // UP P=2
    set_ch(3, 1, 2, 5, 0, 0);   // UP P=5 max masked
    set_ch(4, 1, 0, 1, 0, 2);   // UP P=1 irq every third event
    set_ch(5, 2, 0, 6, 0, 0);   // DOWN P=6
    set_ch(6, 3, 0, 0, 0, 0);   // UPDOWN P=0
    set_ch(7, 0, 0, 7, 0, 0);   // frozen
    step_cycle();
    en = '1;
    for (int k = 0; k < 12; k++) begin
      step_cycle();
      v = (k + 1) % 4;
      check_eq("up_p3_carr", carr_of(0), v);
      check_eq("up_p3_evt", evt[0], (v == 3) || (v == 0));
      check_eq("ud_p4_carr", carr_of(1), ud_seq[k % 8]);
      check_eq("ud_p4_dir", dir[1], ud_dir[k % 8]);
      check_eq("ud_p4_evt", evt[1], ud_seq[k % 8] == 4);
      check_eq("dec3_irq", irq[4], (k % 3) == 2);
    end

    // Shadow period 5 -> 8 written mid-ramp, max events masked
    guard = 0;
    while (carr_of(3) != 2 && guard < 40) begin step_cycle(); guard++; end
    check_eq("p58_reach2", carr_of(3), 2);
    period[3*CNT_W +: CNT_W] = CNT_W'(8);
    mx = 0; guard = 0;
    do begin
      step_cycle();
      if (carr_of(3) > mx) mx = carr_of(3);
      guard++;
    end while (carr_of(3) != 0 && guard < 40);
    check_eq("p58_old_peak", mx, 5);
    for (int k = 1; k <= 8; k++) begin
      step_cycle();
      check_eq("p58_new_ramp", carr_of(3), k);
    end

    // Prescaler: tick every 3 cycles, aligned by sync
    clkdiv_en = 1'b1;
    clkdiv    = DIV_W'(2);
    sync      = 1'b1;
    step_cycle();
    sync = 1'b0;
    check_eq("sync_no_evt", evt, 0);
    for (int k = 1; k <= 18; k++) begin
      step_cycle();
      v = (k / 3) % 3;
      check_eq("div3_carr", carr_of(2), v);
      check_eq("div3_evt", evt[2], ((k % 3) == 0) && (v != 1));
    end

    // Sync with phase beyond the period
    set_ch(5, 1, 0, 8, 10, 0);
    sync = 1'b1;
    step_cycle();
    sync = 1'b0;
`ifdef CARR_PHASE_EN
    exp_sync = 8;
`else
    exp_sync = 0;
`endif
    check_eq("sync_phase_carr", carr_of(5), exp_sync);
    check_eq("sync_phase_evt", evt[5], 1'b0);
    check_eq("sync_phase_dir", dir[5], 1'b0);

    // Randomized traffic with a reset pulse in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) random_config();
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) begin
        v = $urandom_range(0, N_CH - 1);
        period[v*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
        mode[2*v +: 2] = 2'($urandom_range(0, 3));
      end
      if (c == 700) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_carr", carr, 0);
        check_eq("midrst_flags", {dir, evt, irq}, 0);
        model_reset();
        step_cycle();
        rst_n = 1'b1;
      end
      step_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_carrier_bank.md
# pwm_carrier_bank

Parametrised N-channel PWM carrier generator, the successor to the fixed 8-carrier layout. It produces per-channel up, down or up-down carriers with independent period, phase, count mode and update-event mask. It also provides a shared clock prescaler, shadow-period loading on unmasked extrema, and per-channel event-decimated interrupts. It feeds the comparator/dead-time stage and the interrupt controller of the PWM subsystem.

## Interface
Parameters:
- N_CH, 8, number of carrier channels
- CNT_W, 16, carrier counter width
- DIV_W, 4, prescaler setting width
- EVT_W, 3, interrupt event-decimation width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  N_CH  per-channel carrier on (_carr_onoff)
- mode  in  2*N_CH  per-channel _count_mode
- mask  in  2*N_CH  per-channel _mask_mode; bit0 suppresses min events, bit1 suppresses max events
- clkdiv_en  in  1  prescaler on (_clkdiv_onoff)
- clkdiv  in  DIV_W  tick every clkdiv+1 cycles
- period  in  N_CH*CNT_W  shadow period P per channel
- phase  in  N_CH*CNT_W  counter load value on sync
- evt_cnt  in  N_CH*EVT_W  events per interrupt, minus one
- sync  in  1  master synchronisation pulse
- carr  out  N_CH*CNT_W  carrier value
- dir  out  N_CH  1 = counting down
- evt  out  N_CH  one-cycle pulse on an unmasked update event
- irq  out  N_CH  one-cycle pulse every evt_cnt+1 unmasked events

## Operation
- Prescaler: one shared tick.
  - clkdiv_en=0: tick every cycle.
  - clkdiv_en=1: tick when the divider equals clkdiv, then the divider clears.
  - Sync clears the divider.
- Count modes, per tick, with Pa the active period:
  - COUNT_UP: 0..Pa, then wraps to 0; dir=0.
  - COUNT_DOWN: Pa..0, then wraps to Pa; dir=1.
  - COUNT_UPDOWN: 0 up to Pa with dir=0, then down to 0 with dir=1, then up again. Each extremum value is shown for one tick only.
  - NO_COUNT: counter holds; no events.
- Extrema events:
  - A max event occurs when carr becomes Pa. A min event occurs when carr becomes 0.
  - An event is unmasked unless its mask bit is set; MINMAX_MASK produces no events.
- Shadow period: on an unmasked event, Pa is loaded from period. It takes effect from the next tick.
- Pa=0: carr stays 0 and dir=0. One min event occurs per tick; the max event is suppressed.
- en=0:
  - carr=0, dir=0, and Pa tracks period every cycle.
  - The event decimator clears; evt and irq stay 0.
- Sync has priority over the tick:
  - Pa is loaded from period.
  - carr is loaded with min(phase, Pa).
  - dir=1 in COUNT_DOWN, otherwise 0.
  - No event is generated on the sync cycle.
- Interrupt decimation:
  - Each channel has an EVT_W counter that counts unmasked events.
  - When the counter equals evt_cnt, irq pulses and the counter clears.
  - evt_cnt=0 gives one irq per event.
- Changing mode while running: the new mode applies from the next tick. If carr > Pa, the next tick wraps as if carr had reached the extremum.

## Timing
- Reset values: carr=0, dir=0, evt=0, irq=0, Pa=0, divider=0, decimators=0.
- All outputs are registered. carr and dir update in the cycle after the tick.
- evt and irq are high in exactly the first cycle carr shows the extremum value, and are never stretched by the prescaler.
- Reset asserted mid-operation returns all state to reset values immediately; counting resumes on the first tick after release.

## Configuration
- CARR_PHASE_EN
  - Defined: sync loads min(phase, Pa) as specified.
  - Undefined: the phase port is ignored and sync loads 0, with dir as specified.

## Structure
- Package: reuse _count_mode, _mask_mode, _carr_onoff and _clkdiv_onoff. Add CARRCH_WIDTH, default 8, for the N_CH default.
- Sub-module pwm_carr_ch: one channel's counter, dir, shadow period, event detection and decimator.
- The bank holds the shared prescaler and a generate loop of N_CH pwm_carr_ch instances.

## Test plan
- UP, P=3, NO_MASK, no division: carr 0,1,2,3,0,1…; evt at each 3 and each 0.
- UPDOWN, P=4, MIN_MASK: carr 0..4..0, with dir=1 while descending 3,2,1,0; evt only when carr=4.
- clkdiv_en=1, clkdiv=2, UP, P=2: each value is held 3 cycles; evt is 1 cycle wide.
- Period 5→8 written mid-ramp with MAX_MASK: the ramp still reaches 5; the new period is used only after the next 0.
- Sync with phase=10, P=8, CARR_PHASE_EN defined: carr=8 next cycle with no evt. With the macro undefined: carr=0.
- evt_cnt=2, NO_MASK, UP, P=1: irq on every third evt. Reset pulse mid-run: all outputs 0 immediately.
